target_game_core: RTL and testbench

- Parametrised successor to the single-board whack-a-target game controller.
- Owns the game FSM, the setting fields, countdown, scoring and the pseudo-random target pattern.
- Sits between the keyboard decoder/key mapper (upstream) and the LED and seven-segment drivers (downstream).
- Takes enable pulses instead of derived clocks, so everything runs on one clock domain.

---
 rtl/game_pkg.sv | 26 ++
 rtl/lfsr_gen.sv | 23 ++
 rtl/target_game_core.sv | 219 +++++++++++++++++++++
 tb/tb_target_game_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, constants and BCD helpers for target_game_core
package game_pkg;

    // Encoding is visible on the state output port, so values are fixed
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } game_state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic       SET_TIME = 1'b0;
    localparam logic       SET_GOAL = 1'b1;

    // Values never exceed 99, so both digits fit in a nibble
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Digits are always 0..9 because only keys 0..9 are shifted into fields
    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - right-shifting Galois LFSR with seed load and zero-state recovery
module lfsr_gen #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110,
    parameter logic [WIDTH-1:0] SEED  = 9'h160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] q
);

    // Zero is a lock-up state for a Galois LFSR; treat it like a load
    always_ff @(posedge clk) begin
        if (rst || load || (q == '0)) begin
            q <= SEED;
        end else if (advance) begin
            q <= {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/target_game_core.sv
// rtl/target_game_core.sv - game FSM, settings, countdown, scoring; option TARGET_GAME_MISS_PENALTY_EN
module target_game_core
    import game_pkg::*;
#(
    parameter int                N_TGT      = 8,
    parameter int                LFSR_W     = 9,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 9'h160,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 9'h110,
    parameter int                DEF_TIME   = 30,
    parameter int                DEF_GOAL   = 10,
    parameter int                DONE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tick,
    input  logic             step,
    input  logic             key_valid,
    input  logic [3:0]       key_num,
    input  logic             key_mode,
    output logic [N_TGT-1:0] targets,
    output logic [7:0]       time_bcd,
    output logic [7:0]       goal_bcd,
    output logic [7:0]       score_bcd,
    output logic [1:0]       state,
    output logic             set_field,
    output logic             win
);

    localparam logic [7:0] DEF_TIME_BCD = bin2bcd(7'(DEF_TIME));
    localparam logic [7:0] DEF_GOAL_BCD = bin2bcd(7'(DEF_GOAL));
    localparam logic [3:0] N_TGT_K      = 4'(N_TGT);
    localparam logic [7:0] DONE_LAST    = 8'(DONE_TICKS - 1);
    localparam logic [6:0] SCORE_MAX    = 7'd99;

    game_state_t       state_q, state_nxt;
    logic [7:0]        time_fld, time_fld_nxt;
    logic [7:0]        goal_nxt;
    logic              sf_nxt;
    logic [6:0]        time_left, tl_nxt;
    logic [6:0]        score, sc_nxt;
    logic [N_TGT-1:0]  tg_nxt;
    logic              win_nxt;
    logic [7:0]        done_cnt, cnt_nxt;
    logic [7:0]        time_bcd_nxt;
    logic [7:0]        score_bcd_nxt;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_unused;

    logic              digit;
    logic              hit;
    logic [N_TGT-1:0]  key_mask;
    logic [6:0]        goal_bin;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q;
    assign state       = state_q;
    assign digit       = key_valid && (key_num <= 4'd9);
    assign key_mask    = (key_num < N_TGT_K) ? (N_TGT'(1) << key_num) : '0;
    assign hit         = key_valid && |(targets & key_mask);
    assign goal_bin    = bcd2bin(goal_bcd);

    // State and every output are registered from the next-value logic below
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            time_fld  <= DEF_TIME_BCD;
            time_bcd  <= DEF_TIME_BCD;
            goal_bcd  <= DEF_GOAL_BCD;
            set_field <= SET_TIME;
            time_left <= '0;
            score     <= '0;
            score_bcd <= '0;
            targets   <= '0;
            win       <= 1'b0;
            done_cnt  <= '0;
        end else begin
            state_q   <= state_nxt;
            time_fld  <= time_fld_nxt;
            time_bcd  <= time_bcd_nxt;
            goal_bcd  <= goal_nxt;
            set_field <= sf_nxt;
            time_left <= tl_nxt;
            score     <= sc_nxt;
            score_bcd <= score_bcd_nxt;
            targets   <= tg_nxt;
            win       <= win_nxt;
            done_cnt  <= cnt_nxt;
        end
    end

    // Next state and next values of all game registers
    always_comb begin
        state_nxt    = state_q;
        time_fld_nxt = time_fld;
        goal_nxt     = goal_bcd;
        sf_nxt       = set_field;
        tl_nxt       = time_left;
        sc_nxt       = score;
        tg_nxt       = targets;
        win_nxt      = win;
        cnt_nxt      = done_cnt;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                time_fld_nxt = DEF_TIME_BCD;
                goal_nxt     = DEF_GOAL_BCD;
                sf_nxt       = SET_TIME;
                if (start) begin
                    state_nxt = ST_SET;
                end
            end

            ST_SET: begin
                if (start) begin
                    state_nxt = ST_PLAY;
                    tl_nxt    = bcd2bin(time_fld);
                    sc_nxt    = '0;
                    tg_nxt    = '0;
                    win_nxt   = 1'b0;
                    lfsr_load = 1'b1;
                end else begin
                    // Digit lands in the field selected before any toggle this cycle
                    if (digit) begin
                        if (set_field == SET_TIME) begin
                            time_fld_nxt = {time_fld[3:0], key_num};
                        end else begin
                            goal_nxt = {goal_bcd[3:0], key_num};
                        end
                    end
                    if (key_mode) begin
                        sf_nxt = ~set_field;
                    end
                end
            end

            ST_PLAY: begin
                if (tick && (time_left != '0)) begin
                    tl_nxt = time_left - 7'd1;
                end
                if (hit) begin
                    tg_nxt = targets & ~key_mask;
                    if (score < SCORE_MAX) begin
                        sc_nxt = score + 7'd1;
                    end
                end
`ifdef TARGET_GAME_MISS_PENALTY_EN
                else if (digit && (score != '0)) begin
                    sc_nxt = score - 7'd1;
                end
`endif
                // A new pattern replaces the hit-cleared one, the score keeps the hit
                if (step) begin
                    lfsr_adv = 1'b1;
                    tg_nxt   = lfsr_q[N_TGT-1:0];
                end
                // Win is checked first so a last-second hit still counts
                if (sc_nxt >= goal_bin) begin
                    state_nxt = ST_DONE;
                    win_nxt   = 1'b1;
                    tg_nxt    = '1;
                    cnt_nxt   = '0;
                end else if (tl_nxt == '0) begin
                    state_nxt = ST_DONE;
                    win_nxt   = 1'b0;
                    tg_nxt    = '1;
                    cnt_nxt   = '0;
                end
            end

            ST_DONE: begin
                if (tick) begin
                    tg_nxt = ~targets;
                    if (done_cnt == DONE_LAST) begin
                        state_nxt    = ST_IDLE;
                        time_fld_nxt = DEF_TIME_BCD;
                        goal_nxt     = DEF_GOAL_BCD;
                        sf_nxt       = SET_TIME;
                        sc_nxt       = '0;
                        tg_nxt       = '0;
                        win_nxt      = 1'b0;
                        cnt_nxt      = '0;
                    end else begin
                        cnt_nxt = done_cnt + 8'd1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Time display follows the countdown once a game has started
        if ((state_nxt == ST_PLAY) || (state_nxt == ST_DONE)) begin
            time_bcd_nxt = bin2bcd(tl_nxt);
        end else begin
            time_bcd_nxt = time_fld_nxt;
        end
        score_bcd_nxt = bin2bcd(sc_nxt);
    end

endmodule

// File: tb/tb_target_game_core.sv
// tb/tb_target_game_core.sv - directed table-driven bench for target_game_core
module tb_target_game_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       step = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_num = 4'h0;
    logic       key_mode = 1'b0;
    logic [7:0] targets;
    logic [7:0] time_bcd;
    logic [7:0] goal_bcd;
    logic [7:0] score_bcd;
    logic [1:0] state;
    logic       set_field;
    logic       win;

    int checks = 0;
    int errors = 0;

`ifdef TARGET_GAME_MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    target_game_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .step      (step),
        .key_valid (key_valid),
        .key_num   (key_num),
        .key_mode  (key_mode),
        .targets   (targets),
        .time_bcd  (time_bcd),
        .goal_bcd  (goal_bcd),
        .score_bcd (score_bcd),
        .state     (state),
        .set_field (set_field),
        .win       (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, tk, sp, kv;
        logic [3:0] kn;
        logic       km;
        logic [1:0] e_state;
        logic [7:0] e_time, e_goal, e_score, e_tgt;
        logic       e_sf, e_win;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, tk, sp, kv, input logic [3:0] kn, input logic km,
                                input logic [1:0] es, input logic [7:0] et, eg, esc, etg,
                                input logic esf, ew);
        vec_t v;
        v.st = st; v.tk = tk; v.sp = sp; v.kv = kv; v.kn = kn; v.km = km;
        v.e_state = es; v.e_time = et; v.e_goal = eg; v.e_score = esc; v.e_tgt = etg;
        v.e_sf = esf; v.e_win = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, tk, sp, kv, input logic [3:0] kn, input logic km);
        start = st; tick = tk; step = sp; key_valid = kv; key_num = kn; key_mode = km;
        @(posedge clk);
        #1;
        start = 0; tick = 0; step = 0; key_valid = 0; key_num = 4'h0; key_mode = 0;
    endtask

    task automatic do_start();           drive(1, 0, 0, 0, 4'h0, 0); endtask
    task automatic do_tick();            drive(0, 1, 0, 0, 4'h0, 0); endtask
    task automatic do_step();            drive(0, 0, 1, 0, 4'h0, 0); endtask
    task automatic do_key(input logic [3:0] k); drive(0, 0, 0, 1, k, 0); endtask
    task automatic do_mode();            drive(0, 0, 0, 0, 4'h0, 1); endtask
    task automatic do_idle();            drive(0, 0, 0, 0, 4'h0, 0); endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 16'(state), 16'd0);
        chk({tag, "_time"},  16'(time_bcd), 16'h30);
        chk({tag, "_goal"},  16'(goal_bcd), 16'h10);
        chk({tag, "_score"}, 16'(score_bcd), 16'h00);
        chk({tag, "_tgt"},   16'(targets), 16'h00);
        chk({tag, "_sf"},    16'(set_field), 16'd0);
        chk({tag, "_win"},   16'(win), 16'd0);
    endtask

    initial begin
        // st tk sp kv kn km | state time goal score tgt sf win
        tbl.push_back(mk(1,0,0,0,4'h0,0, 2'd1,8'h30,8'h10,8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,4'h4,0, 2'd1,8'h04,8'h10,8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,4'h5,0, 2'd1,8'h45,8'h10,8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,0,0,4'h0,1, 2'd1,8'h45,8'h10,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'h0,0, 2'd1,8'h45,8'h00,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'h3,0, 2'd1,8'h45,8'h03,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'hF,0, 2'd1,8'h45,8'h03,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'h7,1, 2'd1,8'h45,8'h37,8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,0,0,4'h0,1, 2'd1,8'h45,8'h37,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'h0,0, 2'd1,8'h45,8'h70,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,1,4'h3,0, 2'd1,8'h45,8'h03,8'h00,8'h00,1,0));
        tbl.push_back(mk(1,0,0,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,1,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'h60,1,0));
        tbl.push_back(mk(0,0,1,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'hB0,1,0));
        tbl.push_back(mk(0,0,1,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'h58,1,0));
        tbl.push_back(mk(0,0,1,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'h2C,1,0));
        tbl.push_back(mk(0,0,1,0,4'h0,0, 2'd2,8'h45,8'h03,8'h00,8'h16,1,0));
        tbl.push_back(mk(0,0,0,1,4'h4,0, 2'd2,8'h45,8'h03,8'h01,8'h06,1,0));
        tbl.push_back(mk(0,0,1,1,4'h1,0, 2'd2,8'h45,8'h03,8'h02,8'h0B,1,0));
        tbl.push_back(mk(0,0,0,1,4'hF,0, 2'd2,8'h45,8'h03,8'h02,8'h0B,1,0));
        tbl.push_back(mk(0,1,0,0,4'h0,0, 2'd2,8'h44,8'h03,8'h02,8'h0B,1,0));
        tbl.push_back(mk(1,0,0,0,4'h0,0, 2'd2,8'h44,8'h03,8'h02,8'h0B,1,0));
        tbl.push_back(mk(0,0,0,1,4'h3,0, 2'd3,8'h44,8'h03,8'h03,8'hFF,1,1));
        tbl.push_back(mk(1,0,0,0,4'h0,0, 2'd3,8'h44,8'h03,8'h03,8'hFF,1,1));
        tbl.push_back(mk(0,1,0,0,4'h0,0, 2'd3,8'h44,8'h03,8'h03,8'h00,1,1));
        tbl.push_back(mk(0,1,0,0,4'h0,0, 2'd3,8'h44,8'h03,8'h03,8'hFF,1,1));
        tbl.push_back(mk(0,1,0,0,4'h0,0, 2'd3,8'h44,8'h03,8'h03,8'h00,1,1));
        tbl.push_back(mk(0,1,0,0,4'h0,0, 2'd0,8'h30,8'h10,8'h00,8'h00,0,0));

        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk_reset_vals("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].tk, tbl[i].sp, tbl[i].kv, tbl[i].kn, tbl[i].km);
            chk($sformatf("v%0d_state", i), 16'(state), 16'(tbl[i].e_state));
            chk($sformatf("v%0d_time", i),  16'(time_bcd), 16'(tbl[i].e_time));
            chk($sformatf("v%0d_goal", i),  16'(goal_bcd), 16'(tbl[i].e_goal));
            chk($sformatf("v%0d_score", i), 16'(score_bcd), 16'(tbl[i].e_score));
            chk($sformatf("v%0d_tgt", i),   16'(targets), 16'(tbl[i].e_tgt));
            chk($sformatf("v%0d_sf", i),    16'(set_field), 16'(tbl[i].e_sf));
            chk($sformatf("v%0d_win", i),   16'(win), 16'(tbl[i].e_win));
        end

        // Loss by timeout, then DONE_TICKS ticks back to IDLE
        do_reset();
        do_start(); do_key(4'h0); do_key(4'h2);
        chk("loss_setfield", 16'(time_bcd), 16'h02);
        do_start();
        do_tick();
        chk("loss_t1_state", 16'(state), 16'd2);
        chk("loss_t1_time", 16'(time_bcd), 16'h01);
        do_tick();
        chk("loss_state", 16'(state), 16'd3);
        chk("loss_win", 16'(win), 16'd0);
        chk("loss_time", 16'(time_bcd), 16'h00);
        chk("loss_tgt", 16'(targets), 16'hFF);
        do_tick(); do_tick(); do_tick();
        chk("loss_hold_state", 16'(state), 16'd3);
        chk("loss_hold_tgt", 16'(targets), 16'h00);
        do_tick();
        chk("loss_idle_state", 16'(state), 16'd0);
        chk("loss_idle_time", 16'(time_bcd), 16'h30);

        // Final hit on the same edge time_left reaches zero counts as a win
        do_reset();
        do_start(); do_key(4'h0); do_key(4'h1);
        do_mode(); do_key(4'h0); do_key(4'h1);
        chk("tie_goal", 16'(goal_bcd), 16'h01);
        do_start();
        do_step();
        chk("tie_tgt", 16'(targets), 16'h60);
        drive(0, 1, 0, 1, 4'h5, 0);
        chk("tie_state", 16'(state), 16'd3);
        chk("tie_win", 16'(win), 16'd1);
        chk("tie_time", 16'(time_bcd), 16'h00);
        chk("tie_score", 16'(score_bcd), 16'h01);

        // Goal of zero wins one cycle after entering PLAY
        do_reset();
        do_start(); do_mode(); do_key(4'h0); do_key(4'h0);
        do_start();
        chk("g0_entry_state", 16'(state), 16'd2);
        do_idle();
        chk("g0_state", 16'(state), 16'd3);
        chk("g0_win", 16'(win), 16'd1);

        // Reset in the middle of PLAY
        do_reset();
        do_start(); do_start(); do_step(); do_step();
        chk("rstmid_pre_tgt", 16'(targets), 16'hB0);
        rst = 1;
        drive(0, 1, 1, 1, 4'h5, 0);
        rst = 0;
        chk_reset_vals("rstmid");

        // Miss handling, with and without the penalty option
        do_reset();
        do_start(); do_start(); do_step();
        do_key(4'h0);
        chk("miss_at0", 16'(score_bcd), 16'h00);
        do_key(4'h5); do_key(4'h6);
        chk("hits_score", 16'(score_bcd), 16'h02);
        do_step();
        chk("miss_tgt", 16'(targets), 16'hB0);
        do_key(4'h7);
        chk("miss_pre", 16'(score_bcd), 16'h03);
        do_key(4'h0);
        chk("miss_at3", 16'(score_bcd), PEN ? 16'h02 : 16'h03);
        do_key(4'hF);
        chk("miss_nondigit", 16'(score_bcd), PEN ? 16'h02 : 16'h03);
        chk("miss_state", 16'(state), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
